vga_text_attr_reader: RTL and testbench

Display-side reader for the text-mode character and attribute RAMs. Once per scan line it walks one row of character cells, fetching the character code and attribute byte for each cell and looking up that cell's font row. It then serialises eight pixels per cell as 4-bit colour indices toward the palette/DAC stage. It sits between the CRTC timing generator and the palette. The CPU side writes the same RAMs through their other ports.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_text_attr_reader_if.sv | 22 ++
 rtl/vga_pix_shift.sv | 52 +++++
 rtl/vga_text_attr_reader.sv | 141 ++++++++++++++
 tb/tb_vga_text_attr_reader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the text-mode attribute reader.
package vga_pkg;

   localparam int RAM_AW  = 11;
   localparam int FONT_AW = 12;

   // Attribute byte fields
   localparam logic [7:0] ATTR_FG    = 8'h0F;
   localparam logic [7:0] ATTR_BG    = 8'h70;
   localparam logic [7:0] ATTR_BLINK = 8'h80;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_e;

   // Palette index for one pixel of a cell. With blinking enabled bit 7 is
   // the blink flag, so the background loses its bright bit; during the off
   // phase of a blinking cell the foreground collapses onto the background.
   function automatic logic [3:0] cell_colour(input logic [7:0] attr,
                                              input logic       pix_on,
                                              input logic       blink_en,
                                              input logic       blink_phase);
      logic [3:0] fg;
      logic [3:0] bg;
      fg = 4'(attr & ATTR_FG);
      if (blink_en) bg = 4'((attr & ATTR_BG) >> 4);
      else          bg = 4'(attr >> 4);
      if (blink_en && ((attr & ATTR_BLINK) != 8'h00) && !blink_phase) fg = bg;
      return pix_on ? fg : bg;
   endfunction

endpackage

// File: rtl/vga_text_attr_reader_if.sv
// Memory-side bus of the reader: shared char/attr RAM port and font ROM port.
interface vga_text_attr_reader_if;
   import vga_pkg::*;

   logic               ram_cs;
   logic [RAM_AW-1:0]  ram_addr;
   logic [7:0]         char_rdata;
   logic [7:0]         attr_rdata;
   logic [FONT_AW-1:0] font_addr;
   logic [7:0]         font_data;

   modport master (
      output ram_cs, ram_addr, font_addr,
      input  char_rdata, attr_rdata, font_data
   );

   modport slave (
      input  ram_cs, ram_addr, font_addr,
      output char_rdata, attr_rdata, font_data
   );

endinterface

// File: rtl/vga_pix_shift.sv
// Pixel datapath: font holding register, shift register, attribute pipeline
// and colour mux. The fetch sequencing lives in the parent.
module vga_pix_shift
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_attr_we,
   input  logic [7:0] i_attr,
   input  logic       i_hold_we,
   input  logic [7:0] i_font,
   input  logic       i_load_direct,
   input  logic       i_load,
   input  logic       i_shift,
   input  logic       i_valid,
   input  logic       i_blink_en,
   input  logic       i_blink_phase,
   output logic [3:0] o_color
);

   logic [7:0] r_hold;
   logic [7:0] r_shift;
   logic [7:0] r_attr_next;
   logic [7:0] r_attr_act;

   // Capture the next cell's attribute/font, then swap them in at the cell
   // boundary; the first cell of a line loads straight from the font bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= 8'h00;
         r_shift     <= 8'h00;
         r_attr_next <= 8'h00;
         r_attr_act  <= 8'h00;
      end else begin
         if (i_attr_we) r_attr_next <= i_attr;
         if (i_hold_we) r_hold <= i_font;
         if (i_load_direct) begin
            r_shift    <= i_font;
            r_attr_act <= r_attr_next;
         end else if (i_load) begin
            r_shift    <= r_hold;
            r_attr_act <= r_attr_next;
         end else if (i_shift) begin
            r_shift <= {r_shift[6:0], 1'b0};
         end
      end
   end

   assign o_color = i_valid ? cell_colour(r_attr_act, r_shift[7], i_blink_en, i_blink_phase)
                            : 4'h0;

endmodule

// File: rtl/vga_text_attr_reader.sv
// Text-mode scan-line reader: fetches char/attr/font per cell and streams
// eight 4-bit palette indices per cell.
//
//   state | meaning
//   IDLE  | waiting for line_start
//   PRIME | fetching cell 0 (cs, font addr, font data: 3 cycles)
//   RUN   | shifting pixels, prefetching cell k+1 while cell k shifts
module vga_text_attr_reader
   import vga_pkg::*;
#(
   parameter int COLS = 80
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   line_start,
   input  logic [RAM_AW-1:0]      row_base,
   input  logic [3:0]             scan_row,
   input  logic                   blink_en,
   input  logic                   blink_phase,
   vga_text_attr_reader_if.master mem,
   output logic [3:0]             pix_color,
   output logic                   pix_valid,
   output logic                   line_done
);

   localparam logic [RAM_AW-1:0] ADDR_ONE = 1;

   state_e            r_state;
   logic [2:0]        r_ph;
   logic [6:0]        r_col;
   logic [3:0]        r_scan;
   logic              r_ram_cs;
   logic [RAM_AW-1:0] r_ram_addr;
   logic              r_font_en;
   logic              r_hold_en;
   logic              r_pix_valid;
   logic              r_line_done;

   logic w_last_col;
   logic w_fetch_more;
   logic w_load_direct;
   logic w_load;
   logic w_shift;

   assign w_last_col    = (r_col == 7'(COLS - 1));
   // At the end of cell k the fetch issued is for cell k+2
   assign w_fetch_more  = (int'(r_col) + 2 < COLS);
   assign w_load_direct = (r_state == PRIME) && (r_ph == 3'd2);
   assign w_load        = (r_state == RUN) && (r_ph == 3'd7);
   assign w_shift       = (r_state == RUN);

   // Line sequencer: counters, RAM strobe, and the restart path on line_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ph        <= 3'd0;
         r_col       <= 7'd0;
         r_scan      <= 4'd0;
         r_ram_cs    <= 1'b0;
         r_ram_addr  <= '0;
         r_font_en   <= 1'b0;
         r_hold_en   <= 1'b0;
         r_pix_valid <= 1'b0;
         r_line_done <= 1'b0;
      end else begin
         r_ram_cs    <= 1'b0;
         r_line_done <= 1'b0;
         // RAM data returns the cycle after cs, font data the cycle after that
         r_font_en   <= r_ram_cs & ~line_start;
         r_hold_en   <= r_font_en & ~line_start;
         case (r_state)
            IDLE: ;
            PRIME: begin
               if (r_ph == 3'd2) begin
                  r_state     <= RUN;
                  r_ph        <= 3'd0;
                  r_col       <= 7'd0;
                  r_pix_valid <= 1'b1;
                  if (COLS > 1) begin
                     r_ram_cs   <= 1'b1;
                     r_ram_addr <= r_ram_addr + ADDR_ONE;
                  end
               end else begin
                  r_ph <= r_ph + 3'd1;
               end
            end
            RUN: begin
               r_ph <= r_ph + 3'd1;
               if (r_ph == 3'd7) begin
                  if (w_last_col) begin
                     r_state     <= IDLE;
                     r_pix_valid <= 1'b0;
                     r_line_done <= 1'b1;
                  end else begin
                     r_col <= r_col + 7'd1;
                     if (w_fetch_more) begin
                        r_ram_cs   <= 1'b1;
                        r_ram_addr <= r_ram_addr + ADDR_ONE;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         // A new strobe always wins; a coincident line_done is left standing
         if (line_start) begin
            r_state     <= PRIME;
            r_ph        <= 3'd0;
            r_col       <= 7'd0;
            r_scan      <= scan_row;
            r_ram_cs    <= 1'b1;
            r_ram_addr  <= row_base;
            r_pix_valid <= 1'b0;
         end
      end
   end

   assign mem.ram_cs    = r_ram_cs;
   assign mem.ram_addr  = r_ram_addr;
   assign mem.font_addr = r_font_en ? {mem.char_rdata, r_scan} : '0;

   vga_pix_shift u_pix (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_attr_we     (r_font_en),
      .i_attr        (mem.attr_rdata),
      .i_hold_we     (r_hold_en),
      .i_font        (mem.font_data),
      .i_load_direct (w_load_direct),
      .i_load        (w_load),
      .i_shift       (w_shift),
      .i_valid       (r_pix_valid),
      .i_blink_en    (blink_en),
      .i_blink_phase (blink_phase),
      .o_color       (pix_color)
   );

   assign pix_valid = r_pix_valid;
   assign line_done = r_line_done;

endmodule

// File: tb/tb_vga_text_attr_reader.sv
// Bench for vga_text_attr_reader: three instances (COLS = 1, 4, 80) with
// behavioural RAM/ROM models and a pixel/address scoreboard.
module tb_vga_text_attr_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  ls;
   logic [10:0] row_base;
   logic [3:0]  scan_row;
   logic        blink_en;
   logic        blink_phase;

   logic [3:0]  pc [3];
   logic        pv [3];
   logic        ld [3];
   logic        m_cs [3];
   logic [10:0] m_addr [3];
   logic [11:0] m_faddr [3];

   logic [7:0]  char_mem [2048];
   logic [7:0]  attr_mem [2048];
   logic [7:0]  font_mem [4096];

   logic [3:0]  pix_q  [3][$];
   logic [10:0] addr_q [3][$];

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int n_valid [3];
   int n_cs [3];
   int n_gap8 [3];
   int n_done [3];
   int rise_cyc [3];
   int last_pix [3];
   int last_cs [3];
   int first_done [3];
   int done_cyc [3];
   logic [3:0] first_col [3];
   logic [3:0] last_col [3];
   logic pv_d [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   vga_text_attr_reader_if mi0 ();
   vga_text_attr_reader_if mi1 ();
   vga_text_attr_reader_if mi2 ();

   vga_text_attr_reader #(.COLS(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .line_start(ls[0]), .row_base(row_base), .scan_row(scan_row),
      .blink_en(blink_en), .blink_phase(blink_phase), .mem(mi0),
      .pix_color(pc[0]), .pix_valid(pv[0]), .line_done(ld[0]));
   vga_text_attr_reader #(.COLS(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .line_start(ls[1]), .row_base(row_base), .scan_row(scan_row),
      .blink_en(blink_en), .blink_phase(blink_phase), .mem(mi1),
      .pix_color(pc[1]), .pix_valid(pv[1]), .line_done(ld[1]));
   vga_text_attr_reader #(.COLS(80)) u_c80 (
      .clk(clk), .rst_n(rst_n), .line_start(ls[2]), .row_base(row_base), .scan_row(scan_row),
      .blink_en(blink_en), .blink_phase(blink_phase), .mem(mi2),
      .pix_color(pc[2]), .pix_valid(pv[2]), .line_done(ld[2]));

   assign m_cs[0] = mi0.ram_cs;  assign m_addr[0] = mi0.ram_addr;  assign m_faddr[0] = mi0.font_addr;
   assign m_cs[1] = mi1.ram_cs;  assign m_addr[1] = mi1.ram_addr;  assign m_faddr[1] = mi1.font_addr;
   assign m_cs[2] = mi2.ram_cs;  assign m_addr[2] = mi2.ram_addr;  assign m_faddr[2] = mi2.font_addr;

   // Synchronous-read RAMs and font ROM, one copy per instance
   always @(posedge clk) begin
      if (mi0.ram_cs) begin
         mi0.char_rdata <= char_mem[mi0.ram_addr];
         mi0.attr_rdata <= attr_mem[mi0.ram_addr];
      end
      mi0.font_data <= font_mem[mi0.font_addr];
      if (mi1.ram_cs) begin
         mi1.char_rdata <= char_mem[mi1.ram_addr];
         mi1.attr_rdata <= attr_mem[mi1.ram_addr];
      end
      mi1.font_data <= font_mem[mi1.font_addr];
      if (mi2.ram_cs) begin
         mi2.char_rdata <= char_mem[mi2.ram_addr];
         mi2.attr_rdata <= attr_mem[mi2.ram_addr];
      end
      mi2.font_data <= font_mem[mi2.font_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_col(input logic [7:0] at, input logic on);
      logic [3:0] fg;
      logic [3:0] bg;
      fg = at[3:0];
      bg = blink_en ? {1'b0, at[6:4]} : at[7:4];
      if (blink_en && at[7] && !blink_phase) fg = bg;
      return on ? fg : bg;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clr(input int i);
      n_valid[i] = 0;
      n_cs[i]    = 0;
      n_gap8[i]  = 0;
      n_done[i]  = 0;
   endtask

   // Expected fetch addresses and pixels; npix/ncs truncate an aborted line
   task automatic push_line(input int i, input logic [10:0] base, input logic [3:0] scan,
                            input int cols, input int npix, input int ncs);
      int cnt;
      logic [10:0] a;
      logic [7:0] ch;
      logic [7:0] at;
      logic [7:0] f;
      cnt = 0;
      for (int k = 0; k < cols; k++) begin
         a = base + 11'(k);
         if (k < ncs) addr_q[i].push_back(a);
         ch = char_mem[a];
         at = attr_mem[a];
         f  = font_mem[{ch, scan}];
         for (int b = 7; b >= 0; b--) begin
            if (cnt < npix) pix_q[i].push_back(exp_col(at, f[b]));
            cnt++;
         end
      end
   endtask

   task automatic start(input int i, input logic [10:0] base, input logic [3:0] scan,
                        input int cols, input int npix, input int ncs, output int t0);
      row_base = base;
      scan_row = scan;
      ls[i]    = 1'b1;
      t0       = cyc;
      push_line(i, base, scan, cols, npix, ncs);
      step();
      ls[i]    = 1'b0;
      row_base = ~base;
      scan_row = ~scan;
   endtask

   // Scoreboard consumer and timing recorder
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (pv[i]) begin
            if (!pv_d[i]) begin
               rise_cyc[i]  = cyc;
               first_col[i] = pc[i];
            end
            last_pix[i] = cyc;
            last_col[i] = pc[i];
            n_valid[i]++;
            if (pix_q[i].size() > 0) chk($sformatf("pix_u%0d", i), pc[i], pix_q[i].pop_front());
            else chk($sformatf("pix_extra_u%0d", i), pv[i], 0);
         end
         pv_d[i] = pv[i];
         if (m_cs[i]) begin
            if (n_cs[i] > 0 && cyc - last_cs[i] == 8) n_gap8[i]++;
            last_cs[i] = cyc;
            n_cs[i]++;
            if (addr_q[i].size() > 0) chk($sformatf("addr_u%0d", i), m_addr[i], addr_q[i].pop_front());
            else chk($sformatf("cs_extra_u%0d", i), m_cs[i], 0);
         end
         if (ld[i]) begin
            if (n_done[i] == 0) first_done[i] = cyc;
            done_cyc[i] = cyc;
            n_done[i]++;
         end
      end
   end

   initial begin
      int t0;
      int t1;
      rst_n = 1'b0; ls = 3'b000; row_base = '0; scan_row = '0;
      blink_en = 1'b0; blink_phase = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clr(i);
         pv_d[i] = 1'b0;
      end
      for (int i = 0; i < 2048; i++) begin
         char_mem[i] = 8'(i ^ 'h5A);
         attr_mem[i] = 8'(i * 13 + 3);
      end
      for (int i = 0; i < 4096; i++) font_mem[i] = 8'(i * 37 + 11);
      char_mem[11'h123] = 8'h41; attr_mem[11'h123] = 8'h1E; font_mem[12'h415] = 8'hC3;
      for (int k = 0; k < 80; k++) char_mem[11'h200 + 11'(k)] = 8'(k);
      char_mem[11'h300] = 8'h07; attr_mem[11'h300] = 8'h9F;
      font_mem[12'h079] = 8'hFF; font_mem[12'h07A] = 8'h0F;

      repeat (3) step();
      chk("rst_cs",    m_cs[2],   0);
      chk("rst_addr",  m_addr[2], 0);
      chk("rst_faddr", m_faddr[2], 0);
      chk("rst_color", pc[2],     0);
      chk("rst_valid", pv[2],     0);
      chk("rst_done",  ld[2],     0);
      rst_n = 1'b1;
      repeat (3) step();

      // Single cell
      clr(0);
      start(0, 11'h123, 4'h5, 1, 8, 1, t0);
      chk("c1_cs_t1",   m_cs[0],   1);
      chk("c1_addr_t1", m_addr[0], 11'h123);
      step();
      chk("c1_font_addr", m_faddr[0], 12'h415);
      repeat (12) step();
      chk("c1_first_pix", rise_cyc[0], t0 + 4);
      chk("c1_npix",      n_valid[0],  8);
      chk("c1_done_cyc",  done_cyc[0], t0 + 12);
      chk("c1_ndone",     n_done[0],   1);

      // Full 80-column line
      clr(2);
      start(2, 11'h200, 4'h3, 80, 640, 80, t0);
      repeat (660) step();
      chk("c80_ncs",      n_cs[2],     80);
      chk("c80_gap8",     n_gap8[2],   78);
      chk("c80_npix",     n_valid[2],  640);
      chk("c80_first",    rise_cyc[2], t0 + 4);
      chk("c80_last",     last_pix[2], t0 + 643);
      chk("c80_done_cyc", done_cyc[2], t0 + 644);

      // Wrap, then a strobe coincident with the last pixel
      clr(1);
      start(1, 11'h7FE, 4'h6, 4, 32, 4, t0);
      repeat (34) step();
      start(1, 11'h010, 4'h1, 4, 32, 4, t1);
      repeat (40) step();
      chk("c4_first_done", first_done[1], t0 + 36);
      chk("c4_ndone",      n_done[1],     2);
      chk("c4_restart",    rise_cyc[1],   t0 + 39);
      chk("c4_done2",      done_cyc[1],   t1 + 36);
      chk("c4_npix",       n_valid[1],    64);
      chk("c4_ncs",        n_cs[1],       8);

      // Blink behaviour
      blink_en = 1'b1; blink_phase = 1'b1;
      start(0, 11'h300, 4'h9, 1, 8, 1, t0);
      repeat (13) step();
      chk("blink_on",  last_col[0], 4'hF);
      blink_phase = 1'b0;
      start(0, 11'h300, 4'h9, 1, 8, 1, t0);
      repeat (13) step();
      chk("blink_off", last_col[0], 4'h1);
      blink_en = 1'b0; blink_phase = 1'b1;
      start(0, 11'h300, 4'h9, 1, 8, 1, t0);
      repeat (13) step();
      chk("noblink_fg", last_col[0], 4'hF);
      start(0, 11'h300, 4'hA, 1, 8, 1, t0);
      repeat (13) step();
      chk("noblink_bg", first_col[0], 4'h9);

      // Abort in cell 5
      clr(2);
      start(2, 11'h200, 4'h3, 80, 44, 7, t0);
      repeat (46) step();
      start(2, 11'h400, 4'h2, 80, 640, 80, t1);
      chk("abort_valid_drop", pv[2], 0);
      repeat (650) step();
      chk("abort_restart", rise_cyc[2], t1 + 4);
      chk("abort_ndone",   n_done[2],   1);
      chk("abort_done",    done_cyc[2], t1 + 644);
      chk("abort_npix",    n_valid[2],  684);

      // Asynchronous reset mid-RUN
      start(2, 11'h200, 4'h3, 80, 640, 80, t0);
      repeat (30) step();
      rst_n = 1'b0;
      #1;
      chk("arst_valid", pv[2],      0);
      chk("arst_color", pc[2],      0);
      chk("arst_cs",    m_cs[2],    0);
      chk("arst_addr",  m_addr[2],  0);
      chk("arst_faddr", m_faddr[2], 0);
      chk("arst_done",  ld[2],      0);
      pix_q[2].delete();
      addr_q[2].delete();
      step();
      rst_n = 1'b1;
      clr(2);
      repeat (30) step();
      chk("arst_quiet_cs",  n_cs[2],    0);
      chk("arst_quiet_pix", n_valid[2], 0);

      for (int i = 0; i < 3; i++) begin
         chk($sformatf("pix_q_left_u%0d", i),  pix_q[i].size(),  0);
         chk($sformatf("addr_q_left_u%0d", i), addr_q[i].size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
